// File: rtl/dpcm_pkg.sv
// Shared DPCM definitions: default widths, sample/residual types and decoder states.
// The encoder side imports the same package.
package dpcm_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_DIFF_W = 8;

   typedef logic        [DEF_DATA_W-1:0] sample_t;
   typedef logic signed [DEF_DIFF_W-1:0] residual_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      EMIT = 2'd2
   } dpcm_dec_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/dpcm_sat_add.sv
// Combinational unsigned base plus signed residual, clamped to the unsigned sample range.
module dpcm_sat_add
   import dpcm_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DIFF_W = DEF_DIFF_W
) (
   input  logic        [DATA_W-1:0] base,
   input  logic signed [DIFF_W-1:0] residual,
   output logic        [DATA_W-1:0] result,
   output logic                     sat
);

   // Two guard bits hold both the negative range and the carry out of the sample width.
   localparam int SUM_W = max_int(DATA_W, DIFF_W) + 2;
   localparam logic signed [SUM_W-1:0] MAX_VAL = {{(SUM_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};

   logic signed [SUM_W-1:0] base_ext;
   logic signed [SUM_W-1:0] res_ext;
   logic signed [SUM_W-1:0] sum;

   assign base_ext = {{(SUM_W-DATA_W){1'b0}}, base};
   assign res_ext  = {{(SUM_W-DIFF_W){residual[DIFF_W-1]}}, residual};
   assign sum      = base_ext + res_ext;

   always_comb begin
      result = sum[DATA_W-1:0];
      sat    = 1'b0;
      if (sum[SUM_W-1]) begin
         result = '0;
         sat    = 1'b1;
      end else if (sum > MAX_VAL) begin
         result = '1;
         sat    = 1'b1;
      end
   end

endmodule

// File: rtl/dpcm_decoder.sv
// DPCM decoder: rebuilds samples as clamp(prediction + residual) through an
// IDLE/CALC/EMIT handshake, one sample in flight at a time.
module dpcm_decoder
   import dpcm_pkg::*;
#(
   parameter int                DATA_W    = DEF_DATA_W,
   parameter int                DIFF_W    = DEF_DIFF_W,
   parameter logic [DATA_W-1:0] PRED_INIT = '0,
   parameter int                CNT_W     = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DIFF_W-1:0] in_residual,
   input  logic                     in_sof,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic        [DATA_W-1:0] out_sample,
   output logic                     out_sof,
   output logic                     out_sat,
   output logic        [CNT_W-1:0]  sat_count,
   output logic        [1:0]        state_o
);

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_CALC = CALC;
   localparam logic [1:0] ST_EMIT = EMIT;

   logic        [1:0]        state;
   logic signed [DIFF_W-1:0] res_q;
   logic                     sof_q;
   logic        [DATA_W-1:0] predictor;
   logic        [DATA_W-1:0] base;
   logic        [DATA_W-1:0] clamped;
   logic                     clamp_sat;

   // A start-of-frame residual ignores the running predictor and restarts from the seed.
   assign base = sof_q ? PRED_INIT : predictor;

   dpcm_sat_add #(
      .DATA_W(DATA_W),
      .DIFF_W(DIFF_W)
   ) u_sat_add (
      .base    (base),
      .residual(res_q),
      .result  (clamped),
      .sat     (clamp_sat)
   );

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_EMIT);
   assign state_o   = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         res_q      <= '0;
         sof_q      <= 1'b0;
         predictor  <= PRED_INIT;
         out_sample <= '0;
         out_sof    <= 1'b0;
         out_sat    <= 1'b0;
         sat_count  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  res_q <= in_residual;
                  sof_q <= in_sof;
                  state <= ST_CALC;
               end
            end
            ST_CALC: begin
               out_sample <= clamped;
               out_sof    <= sof_q;
               out_sat    <= clamp_sat;
               predictor  <= clamped;
               if (clamp_sat && (sat_count != '1)) begin
                  sat_count <= sat_count + CNT_W'(1);
               end
               state <= ST_EMIT;
            end
            ST_EMIT: begin
               if (out_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dpcm_decoder.sv
// Directed self-checking bench for dpcm_decoder; a second instance with a 3-bit
// counter exercises sat_count saturation within a short run.
module tb_dpcm_decoder;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_residual = '0;
   logic        in_sof = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [7:0]  out_sample;
   logic        out_sof;
   logic        out_sat;
   logic [15:0] sat_count;
   logic [1:0]  state_o;

   logic        small_in_ready;
   logic        small_out_valid;
   logic [7:0]  small_out_sample;
   logic        small_out_sof;
   logic        small_out_sat;
   logic [2:0]  small_sat_count;
   logic [1:0]  small_state;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dpcm_decoder dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_residual(in_residual),
      .in_sof     (in_sof),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_sample (out_sample),
      .out_sof    (out_sof),
      .out_sat    (out_sat),
      .sat_count  (sat_count),
      .state_o    (state_o)
   );

   dpcm_decoder #(.CNT_W(3)) dut_small (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (small_in_ready),
      .in_residual(in_residual),
      .in_sof     (in_sof),
      .out_valid  (small_out_valid),
      .out_ready  (out_ready),
      .out_sample (small_out_sample),
      .out_sof    (small_out_sof),
      .out_sat    (small_out_sat),
      .sat_count  (small_sat_count),
      .state_o    (small_state)
   );

   // Starts at posedge+1 in IDLE; completes the output transfer only if out_ready is high.
   task automatic run_sample(input logic [7:0] res, input logic sof,
                             output logic [7:0] smp, output logic sof_o,
                             output logic sat_o, output bit ok);
      ok = 1'b0; smp = '0; sof_o = 1'b0; sat_o = 1'b0;
      in_valid = 1'b1; in_residual = res; in_sof = sof;
      @(posedge clk); #1;
      in_valid = 1'b0; in_sof = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      if (ok) begin
         smp = out_sample; sof_o = out_sof; sat_o = out_sat;
      end
      if (out_ready) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks += 7;
      if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got=%0b exp=1", in_ready); end
      if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%0b exp=0", out_valid); end
      if (out_sample !== 8'd0) begin failures++; $display("[TB] FAIL reset_out_sample got=%0d exp=0", out_sample); end
      if (out_sof !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_sof got=%0b exp=0", out_sof); end
      if (out_sat !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_sat got=%0b exp=0", out_sat); end
      if (sat_count !== 16'd0) begin failures++; $display("[TB] FAIL reset_sat_count got=%0d exp=0", sat_count); end
      if (state_o !== 2'd0) begin failures++; $display("[TB] FAIL reset_state got=%0d exp=0", state_o); end
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      logic [7:0] res_v [3] = '{8'd10, 8'd5, 8'hFD};
      logic [7:0] exp_v [3] = '{8'd10, 8'd15, 8'd12};
      logic [7:0] smp;
      logic       sof_o, sat_o;
      bit         ok;
      int         highs, first_hi, second_hi;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         run_sample(res_v[k], 1'b0, smp, sof_o, sat_o, ok);
         checks += 2;
         if (!ok) begin failures++; $display("[TB] FAIL basic_timeout idx=%0d", k); end
         else if (smp !== exp_v[k]) begin failures++; $display("[TB] FAIL basic_sample idx=%0d got=%0d exp=%0d", k, smp, exp_v[k]); end
         if (sat_o !== 1'b0) begin failures++; $display("[TB] FAIL basic_sat idx=%0d got=%0b exp=0", k, sat_o); end
      end
      // Continuous input with zero residual: out_valid should pulse every third cycle.
      highs = 0; first_hi = -1; second_hi = -1;
      in_valid = 1'b1; in_residual = 8'd0;
      for (int c = 1; c <= 9; c++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            highs++;
            if (first_hi < 0) first_hi = c;
            else if (second_hi < 0) second_hi = c;
         end
      end
      in_valid = 1'b0;
      checks += 3;
      if (highs != 3) begin failures++; $display("[TB] FAIL basic_valid_count got=%0d exp=3", highs); end
      if (second_hi - first_hi != 3) begin failures++; $display("[TB] FAIL basic_valid_period got=%0d exp=3", second_hi - first_hi); end
      if (out_sample !== 8'd12) begin failures++; $display("[TB] FAIL basic_zero_residual got=%0d exp=12", out_sample); end
   endtask

   task automatic test_clamp_high();
      logic [7:0] smp;
      logic       sof_o, sat_o;
      bit         ok;
      run_sample(8'd127, 1'b0, smp, sof_o, sat_o, ok);
      run_sample(8'd111, 1'b0, smp, sof_o, sat_o, ok);
      checks++;
      if (smp !== 8'd250) begin failures++; $display("[TB] FAIL high_setup got=%0d exp=250", smp); end
      run_sample(8'd20, 1'b0, smp, sof_o, sat_o, ok);
      checks += 3;
      if (smp !== 8'd255) begin failures++; $display("[TB] FAIL high_clamp got=%0d exp=255", smp); end
      if (sat_o !== 1'b1) begin failures++; $display("[TB] FAIL high_sat got=%0b exp=1", sat_o); end
      if (sat_count !== 16'd1) begin failures++; $display("[TB] FAIL high_sat_count got=%0d exp=1", sat_count); end
      run_sample(8'h80, 1'b0, smp, sof_o, sat_o, ok);
      checks += 2;
      if (smp !== 8'd127) begin failures++; $display("[TB] FAIL high_neg128 got=%0d exp=127", smp); end
      if (sat_o !== 1'b0) begin failures++; $display("[TB] FAIL high_neg128_sat got=%0b exp=0", sat_o); end
   endtask

   task automatic test_clamp_low();
      logic [7:0] smp;
      logic       sof_o, sat_o;
      bit         ok;
      run_sample(8'h86, 1'b0, smp, sof_o, sat_o, ok);
      checks++;
      if (smp !== 8'd5) begin failures++; $display("[TB] FAIL low_setup got=%0d exp=5", smp); end
      run_sample(8'hF7, 1'b0, smp, sof_o, sat_o, ok);
      checks += 3;
      if (smp !== 8'd0) begin failures++; $display("[TB] FAIL low_clamp got=%0d exp=0", smp); end
      if (sat_o !== 1'b1) begin failures++; $display("[TB] FAIL low_sat got=%0b exp=1", sat_o); end
      if (sat_count !== 16'd2) begin failures++; $display("[TB] FAIL low_sat_count got=%0d exp=2", sat_count); end
      for (int k = 0; k < 7; k++) begin
         run_sample(8'hFF, 1'b0, smp, sof_o, sat_o, ok);
      end
      checks += 2;
      if (sat_count !== 16'd9) begin failures++; $display("[TB] FAIL low_sat_count_many got=%0d exp=9", sat_count); end
      if (small_sat_count !== 3'd7) begin failures++; $display("[TB] FAIL low_sat_count_ceiling got=%0d exp=7", small_sat_count); end
   endtask

   task automatic test_sof();
      logic [7:0] smp;
      logic       sof_o, sat_o;
      bit         ok;
      run_sample(8'd100, 1'b0, smp, sof_o, sat_o, ok);
      run_sample(8'd100, 1'b0, smp, sof_o, sat_o, ok);
      checks++;
      if (smp !== 8'd200) begin failures++; $display("[TB] FAIL sof_setup got=%0d exp=200", smp); end
      run_sample(8'd7, 1'b1, smp, sof_o, sat_o, ok);
      checks += 2;
      if (smp !== 8'd7) begin failures++; $display("[TB] FAIL sof_sample got=%0d exp=7", smp); end
      if (sof_o !== 1'b1) begin failures++; $display("[TB] FAIL sof_flag got=%0b exp=1", sof_o); end
      run_sample(8'd1, 1'b0, smp, sof_o, sat_o, ok);
      checks += 2;
      if (smp !== 8'd8) begin failures++; $display("[TB] FAIL sof_next got=%0d exp=8", smp); end
      if (sof_o !== 1'b0) begin failures++; $display("[TB] FAIL sof_next_flag got=%0b exp=0", sof_o); end
   endtask

   task automatic test_backpressure();
      logic [7:0] smp;
      logic       sof_o, sat_o;
      bit         ok;
      out_ready = 1'b0;
      run_sample(8'd2, 1'b0, smp, sof_o, sat_o, ok);
      checks++;
      if (!ok || smp !== 8'd10) begin failures++; $display("[TB] FAIL bp_first got=%0d ok=%0b exp=10", smp, ok); end
      for (int c = 0; c < 10; c++) begin
         in_valid = c[0]; in_residual = 8'd50;
         @(posedge clk); #1;
         checks += 3;
         if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_hold_valid cyc=%0d got=%0b exp=1", c, out_valid); end
         if (out_sample !== 8'd10) begin failures++; $display("[TB] FAIL bp_hold_sample cyc=%0d got=%0d exp=10", c, out_sample); end
         if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_in_ready cyc=%0d got=%0b exp=0", c, in_ready); end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      checks += 2;
      if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_release_valid got=%0b exp=0", out_valid); end
      if (state_o !== 2'd0) begin failures++; $display("[TB] FAIL bp_release_state got=%0d exp=0", state_o); end
      run_sample(8'd1, 1'b0, smp, sof_o, sat_o, ok);
      checks++;
      if (smp !== 8'd11) begin failures++; $display("[TB] FAIL bp_after got=%0d exp=11", smp); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] smp;
      logic       sof_o, sat_o;
      bit         ok;
      in_valid = 1'b1; in_residual = 8'd5;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (state_o !== 2'd1) begin failures++; $display("[TB] FAIL mid_in_calc got=%0d exp=1", state_o); end
      reset = 1'b1;
      #1;
      checks += 3;
      if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_out_valid got=%0b exp=0", out_valid); end
      if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL mid_in_ready got=%0b exp=1", in_ready); end
      if (sat_count !== 16'd0) begin failures++; $display("[TB] FAIL mid_sat_count got=%0d exp=0", sat_count); end
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      run_sample(8'd3, 1'b0, smp, sof_o, sat_o, ok);
      checks++;
      if (smp !== 8'd3) begin failures++; $display("[TB] FAIL mid_pred_reseed got=%0d exp=3", smp); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_clamp_high();
      test_clamp_low();
      test_sof();
      test_backpressure();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
